sudoku_loader: RTL

SUDOKU_LOADER -- requirements
Module: sudoku_loader

---
 rtl/sudoku_loader.sv | 105 ++++++++++
 1 files changed

// File: rtl/sudoku_loader.sv
// Loads an order-9 sudoku puzzle, one raster-ordered cell per transfer, into a one-hot 729-bit image.
// Optional given-cell counter and port enabled by defining SUDOKU_LOADER_GIVEN_COUNT_EN.
module sudoku_loader (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         cell_valid,
    input  logic [3:0]   cell_digit,
    output logic         cell_ready,
    output logic [728:0] puzzle_reg_bin,
    output logic         load_busy,
    output logic         load_done,
    output logic         load_err
`ifdef SUDOKU_LOADER_GIVEN_COUNT_EN
    ,
    output logic [6:0]   given_count
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [6:0]  idx;
    logic [9:0]  base;
    logic [8:0]  onehot;
    logic        xfer;
    logic        legal_given;
    logic        illegal;
`ifdef SUDOKU_LOADER_GIVEN_COUNT_EN
    logic [6:0]  count;
    assign given_count = count;
`endif

    assign cell_ready  = (state == LOAD);
    assign load_busy   = (state == LOAD);
    assign xfer        = cell_valid && cell_ready;
    assign legal_given = (cell_digit >= 4'd1) && (cell_digit <= 4'd9);
    assign illegal     = (cell_digit >= 4'd10);
    assign base        = {3'b000, idx} * 10'd9;

    // Empty and illegal digits both produce an all-zero field.
    always_comb begin
        onehot = 9'd0;
        if (legal_given)
            onehot = 9'd1 << (cell_digit - 4'd1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = LOAD;
            LOAD:    if (xfer && (idx == 7'd80)) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // load_done mirrors the DONE state but comes straight from a flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx            <= 7'd0;
            puzzle_reg_bin <= '0;
            load_err       <= 1'b0;
            load_done      <= 1'b0;
`ifdef SUDOKU_LOADER_GIVEN_COUNT_EN
            count          <= 7'd0;
`endif
        end else begin
            load_done <= 1'b0;
            if ((state == IDLE) && start) begin
                idx            <= 7'd0;
                puzzle_reg_bin <= '0;
                load_err       <= 1'b0;
`ifdef SUDOKU_LOADER_GIVEN_COUNT_EN
                count          <= 7'd0;
`endif
            end else if (xfer) begin
                puzzle_reg_bin[base +: 9] <= onehot;
                if (illegal)
                    load_err <= 1'b1;
`ifdef SUDOKU_LOADER_GIVEN_COUNT_EN
                if (legal_given)
                    count <= count + 7'd1;
`endif
                if (idx == 7'd80)
                    load_done <= 1'b1;
                else
                    idx <= idx + 7'd1;
            end
        end
    end

endmodule
